// File: rtl/io_sequencer_if.sv
// rtl/io_sequencer_if.sv - request/response bundle between the control unit and io_sequencer
interface io_sequencer_if;
    logic        io_req;
    logic [1:0]  io_op;
    logic [31:0] saida;
    logic        busy;
    logic        done;
    logic [15:0] entrada;
    logic [31:0] bcd;
    logic        overflow;
`ifdef IO_SIGNED_EN
    logic        neg;

    modport master (output io_req, io_op, saida,
                    input  busy, done, entrada, bcd, overflow, neg);
    modport slave  (input  io_req, io_op, saida,
                    output busy, done, entrada, bcd, overflow, neg);
`else
    modport master (output io_req, io_op, saida,
                    input  busy, done, entrada, bcd, overflow);
    modport slave  (input  io_req, io_op, saida,
                    output busy, done, entrada, bcd, overflow);
`endif
endinterface

// File: rtl/io_sequencer.sv
// rtl/io_sequencer.sv - I/O instruction sequencer: debounced switch input, shift-add-3 BCD output (IO_SIGNED_EN: signed saida)
module io_sequencer #(
    parameter int DEB_CYCLES  = 50000,
    parameter int CONV_CYCLES = 32
) (
    input  logic          sys_clock,
    input  logic          reset,
    input  logic [15:0]   switches,
    input  logic          confirm_n,
    io_sequencer_if.slave io
);
    typedef enum logic [2:0] {IDLE, IN_WAIT, IN_RELEASE, OUT_CONV, DONE} state_t;

    state_t      state;
    logic        sync1, sync2, deb_level;
    logic [15:0] deb_cnt;
    logic        deb_flip, press_evt, release_evt;
    logic [31:0] shift_reg;
    logic [39:0] scratch, adj, next_scratch;
    logic [5:0]  iter;
    logic [31:0] conv_in;

    assign deb_flip    = (sync2 != deb_level) && (32'(deb_cnt) + 32'd1 == 32'(DEB_CYCLES));
    assign press_evt   = deb_flip & deb_level;
    assign release_evt = deb_flip & ~deb_level;

`ifdef IO_SIGNED_EN
    logic neg_pend;
    assign conv_in = io.saida[31] ? (~io.saida + 32'd1) : io.saida;
`else
    assign conv_in = io.saida;
`endif

    always_comb begin
        adj = scratch;
        for (int d = 0; d < 10; d++) begin
            if (scratch[4*d +: 4] >= 4'd5)
                adj[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
        end
        next_scratch = {adj[38:0], shift_reg[31]};
    end

    always_ff @(posedge sys_clock or posedge reset) begin
        if (reset) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            deb_level <= 1'b1;
            deb_cnt   <= 16'd0;
        end else begin
            sync1 <= confirm_n;
            sync2 <= sync1;
            if (sync2 == deb_level || deb_flip)
                deb_cnt <= 16'd0;
            else
                deb_cnt <= deb_cnt + 16'd1;
            if (deb_flip)
                deb_level <= ~deb_level;
        end
    end

    always_ff @(posedge sys_clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            io.busy     <= 1'b0;
            io.done     <= 1'b0;
            io.entrada  <= 16'd0;
            io.bcd      <= 32'd0;
            io.overflow <= 1'b0;
            shift_reg   <= 32'd0;
            scratch     <= 40'd0;
            iter        <= 6'd0;
`ifdef IO_SIGNED_EN
            io.neg      <= 1'b0;
            neg_pend    <= 1'b0;
`endif
        end else begin
            io.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (io.io_req && io.io_op == 2'd1) begin
                        state   <= IN_WAIT;
                        io.busy <= 1'b1;
                    end else if (io.io_req && io.io_op == 2'd2) begin
                        state     <= OUT_CONV;
                        io.busy   <= 1'b1;
                        shift_reg <= conv_in;
                        scratch   <= 40'd0;
                        iter      <= 6'd0;
`ifdef IO_SIGNED_EN
                        neg_pend  <= io.saida[31];
`endif
                    end
                end
                IN_WAIT: begin
                    if (press_evt) begin
                        io.entrada <= switches;
                        state      <= IN_RELEASE;
                    end
                end
                IN_RELEASE: begin
                    if (release_evt) begin
                        state   <= DONE;
                        io.done <= 1'b1;
                    end
                end
                OUT_CONV: begin
                    scratch   <= next_scratch;
                    shift_reg <= {shift_reg[30:0], 1'b0};
                    iter      <= iter + 6'd1;
                    if (iter == 6'(CONV_CYCLES - 1)) begin
                        // a carry out of digit 9 can only mean an out-of-range magnitude
                        io.bcd      <= next_scratch[31:0];
                        io.overflow <= |{adj[39], next_scratch[39:32]};
`ifdef IO_SIGNED_EN
                        io.neg      <= neg_pend;
`endif
                        state   <= DONE;
                        io.done <= 1'b1;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    io.busy <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    io.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/io_sequencer.md
Name: io_sequencer

Overview:
- Controller that sequences the processor's I/O instructions for the FPGA board.
- io_op=1 (input): stalls the core until the user confirms a value on the switches with a debounced push-button, then latches the value.
- io_op=2 (output): converts the 32-bit result to packed BCD with an iterative shift-add-3 engine, replacing combinational divide/modulo chains.
- Sits between the control unit (req/busy/done handshake) and the 7-segment decoder, which consumes bcd.

Parameters:
- DEB_CYCLES, 50000: consecutive stable cycles required to accept a button level change; legal range 1..65535.
- CONV_CYCLES, 32: shift iterations per conversion; fixed to the saida width, not to be overridden.

Ports:
- sys_clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  reset, asynchronous, active-high.
- io_req  input  1  start request; sampled only in IDLE.
- io_op  input  2  operation code: 0 none, 1 input, 2 output, 3 reserved.
- switches  input  16  raw board switches.
- confirm_n  input  1  raw confirm key, active-low, asynchronous to sys_clock.
- saida  input  32  value to display; sampled on the accept cycle.
- busy  output  1  high whenever state is not IDLE; the core stalls on it.
- done  output  1  one-cycle completion pulse.
- entrada  output  16  last latched switch value.
- bcd  output  32  8 packed BCD digits; digit 0 in [3:0].
- overflow  output  1  value exceeds 99,999,999.

Behaviour:
- Reset values: busy=0, done=0, entrada=0, bcd=0, overflow=0, state=IDLE. Synchronizer flops and the debounced level reset to 1 (released); debounce counter resets to 0.
- Reset asserted mid-operation aborts the operation. No done pulse is produced and the partial result is discarded.
- States: IDLE, IN_WAIT, IN_RELEASE, OUT_CONV, DONE.
- IDLE:
  - io_req=1 with io_op=1 -> IN_WAIT.
  - io_req=1 with io_op=2 -> OUT_CONV; saida is captured into the shift register, and the 40-bit (10-digit) scratch and the iteration counter are cleared.
  - io_op of 0 or 3 -> request ignored; remain in IDLE with no done pulse.
- io_req in any state other than IDLE is ignored; no queuing.
- Debounce:
  - confirm_n passes through a 2-flop synchronizer.
  - The counter increments while the synchronized level differs from the debounced level and clears when they match.
  - When the counter reaches DEB_CYCLES, the debounced level flips and the counter clears.
  - press event = debounced 1->0; release event = debounced 0->1.
  - The debouncer runs in every state.
- IN_WAIT: on a press event, entrada <= switches sampled in that same cycle, then -> IN_RELEASE. A button already held when the request arrives does not count until it is released and pressed again.
- IN_RELEASE: release event -> DONE.
- OUT_CONV, one iteration per cycle:
  - Add 3 to every scratch digit that is >= 5.
  - Shift {scratch, shift register} left by 1.
  - After exactly 32 iterations -> DONE.
- Entering DONE from OUT_CONV:
  - bcd <= scratch[31:0].
  - overflow <= (scratch[39:32] != 0).
  - Both hold until the next completed output operation; an input operation does not change them.
- DONE: done=1 for this cycle only, busy still 1; -> IDLE next cycle.
- Output latency: io_req accepted at edge N -> done high for the cycle after edge N+32; busy is high for 33 cycles.
- saida changes after the accept cycle do not affect the result.

Optional Feature:
- Macro: IO_SIGNED_EN.
- Defined:
  - saida is treated as two's complement; the magnitude is converted, computed as ~saida+1 when saida[31]=1.
  - An extra output port neg (1 bit, reset 0) is updated together with bcd.
  - 0x80000000 converts to magnitude 2147483648 with overflow=1 and neg=1.
- Undefined: saida is unsigned, there is no neg port, and 0xFFFFFFFF converts to 4294967295 with overflow=1.

Test Plan:
- io_op=2, saida=12345678, io_req 1 cycle -> busy 33 cycles; done pulse after 33 edges; bcd=0x12345678, overflow=0.
- saida=100000000 -> bcd=0x00000000, overflow=1. Follow with saida=0 -> bcd=0x00000000, overflow=0.
- DEB_CYCLES=4: io_op=1, switches=0xBEEF, confirm_n bounces with 2-cycle glitches then held low 10 cycles then released -> entrada=0xBEEF, latched exactly once. done follows the debounced release; glitches produce no event.
- Reset pulse at iteration 10 of a conversion of 99999999 -> no done, bcd=0, busy=0. A new request afterwards completes normally with bcd=0x99999999.
- io_req with io_op=2 while in IN_WAIT -> ignored; the input operation completes and a later conversion runs only if re-requested. io_op=3 in IDLE -> busy stays 0.
- IO_SIGNED_EN defined, saida=0xFFFFFFD6 (-42) -> bcd=0x00000042, neg=1, overflow=0.
